// File: rtl/ssg_cmd_pkg.sv
// Shared definitions for the tone/status command decoder:
// opcodes, byte field positions, FSM encoding and lane helpers.
package ssg_cmd_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] OP_TONE   = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  localparam int OP_HI   = 7;
  localparam int OP_LO   = 6;
  localparam int CH_HI   = 5;
  localparam int CH_LO   = 4;
  localparam int HI_HI   = 3;
  localparam int HI_LO   = 0;
  localparam int MASK_HI = 3;
  localparam int MASK_LO = 2;
  localparam int VAL_HI  = 1;
  localparam int VAL_LO  = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } state_e;

  // Place a 2-bit field into the status lane owned by channel ch.
  function automatic logic [2*NUM_CH-1:0] status_lane(
    input logic [1:0] ch,
    input logic [1:0] v
  );
    return (2*NUM_CH)'(v) << {ch, 1'b0};
  endfunction

  function automatic logic [NUM_CH-1:0] ch_onehot(
    input logic [1:0] ch
  );
    return NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Loadable, clearable idle counter with a terminal-count flag
// that fires when the count sits at TIMEOUT-1.
module cmd_timeout_counter #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic [TO_W-1:0] load_val,
  input  logic            inc,
  output logic            tc
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/command_decoder.sv
// Host byte-stream decoder generating tone/status register
// write strobes; all outputs are registered, one cycle after accept.
module command_decoder
  import ssg_cmd_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic [11:0] ToneValue,
  output logic [3:0]  ToneWE,
  output logic [7:0]  Status,
  output logic [7:0]  StatusWE,
  output logic        CmdError
);

  state_e      state_q;
  state_e      state_d;
  logic [1:0]  ch_q;
  logic [1:0]  ch_d;
  logic [3:0]  hi_q;
  logic [3:0]  hi_d;
  logic        ready_q;
  logic [11:0] tone_val_q;
  logic [11:0] tone_val_d;
  logic [3:0]  tone_we_q;
  logic [3:0]  tone_we_d;
  logic [7:0]  status_q;
  logic [7:0]  status_d;
  logic [7:0]  status_we_q;
  logic [7:0]  status_we_d;
  logic        err_q;
  logic        err_d;

  logic        accept;
  logic [1:0]  op;
  logic [1:0]  in_ch;
  logic        to_clr;
  logic        to_inc;
  logic        to_tc;

  assign accept = ByteValid & ready_q;
  assign op     = ByteIn[OP_HI:OP_LO];
  assign in_ch  = ByteIn[CH_HI:CH_LO];

  cmd_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk      (CLK),
    .rst_n    (RST),
    .clr      (to_clr),
    .load     (1'b0),
    .load_val ({TO_W{1'b0}}),
    .inc      (to_inc),
    .tc       (to_tc)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    hi_d        = hi_q;
    tone_val_d  = tone_val_q;
    tone_we_d   = '0;
    status_d    = status_q;
    status_we_d = '0;
    err_d       = 1'b0;
    to_clr      = 1'b0;
    to_inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (op == OP_TONE): begin
              state_d = WAIT_LO;
              ch_d    = in_ch;
              hi_d    = ByteIn[HI_HI:HI_LO];
              to_clr  = 1'b1;
            end
            (op == OP_STATUS): begin
              status_we_d = status_lane(in_ch, ByteIn[MASK_HI:MASK_LO]);
              status_d    = status_lane(in_ch, ByteIn[VAL_HI:VAL_LO]);
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      WAIT_LO: begin
        // A byte arriving on the terminal cycle still completes the write.
        if (accept) begin
          state_d    = IDLE;
          tone_val_d = {hi_q, ByteIn};
          tone_we_d  = ch_onehot(ch_q);
        end else if (to_tc) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      hi_q        <= '0;
      ready_q     <= 1'b0;
      tone_val_q  <= '0;
      tone_we_q   <= '0;
      status_q    <= '0;
      status_we_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      hi_q        <= hi_d;
      ready_q     <= 1'b1;
      tone_val_q  <= tone_val_d;
      tone_we_q   <= tone_we_d;
      status_q    <= status_d;
      status_we_q <= status_we_d;
      err_q       <= err_d;
    end
  end

  assign ByteReady = ready_q;
  assign ToneValue = tone_val_q;
  assign ToneWE    = tone_we_q;
  assign Status    = status_q;
  assign StatusWE  = status_we_q;
  assign CmdError  = err_q;

endmodule

// File: tb/tb_command_decoder.sv
// Scoreboard bench: directed and random byte streams against a
// transaction-level model of the command protocol.
module tb_command_decoder;

  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  ByteIn = 8'h00;
  logic        ByteValid = 1'b0;
  logic        ByteReady;
  logic [11:0] ToneValue;
  logic [3:0]  ToneWE;
  logic [7:0]  Status;
  logic [7:0]  StatusWE;
  logic        CmdError;

  command_decoder #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ByteIn    (ByteIn),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .ToneValue (ToneValue),
    .ToneWE    (ToneWE),
    .Status    (Status),
    .StatusWE  (StatusWE),
    .CmdError  (CmdError)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] tone_we;
    logic [7:0] status_we;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference state: what the host protocol implies, not the RTL's FSM.
  bit          exp_ready = 1'b0;
  bit          pending = 1'b0;
  int          pend_ch;
  int          pend_hi;
  int          idle_run;
  logic [11:0] held_tone = '0;
  logic [7:0]  held_status = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] twe, input logic [7:0] swe,
                      input logic er);
    exp_t e;
    e.tone_we   = twe;
    e.status_we = swe;
    e.err       = er;
    e.cyc       = cyc;
    q.push_back(e);
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    bit acc;
    int ch;
    acc = v && exp_ready;
    ch  = int'(b[5:4]);
    if (acc && pending) begin
      pending   = 1'b0;
      held_tone = 12'(pend_hi * 256 + int'(b));
      push(4'(1 << pend_ch), 8'h00, 1'b0);
    end else if (acc && b[7:6] == 2'b10) begin
      pending  = 1'b1;
      pend_ch  = ch;
      pend_hi  = int'(b[3:0]);
      idle_run = 0;
    end else if (acc && b[7:6] == 2'b11) begin
      held_status = 8'(int'(b[1:0]) << (2 * ch));
      push(4'h0, 8'(int'(b[3:2]) << (2 * ch)), 1'b0);
    end else if (acc) begin
      push(4'h0, 8'h00, 1'b1);
    end else if (pending) begin
      idle_run++;
      if (idle_run == TIMEOUT) begin
        pending = 1'b0;
        push(4'h0, 8'h00, 1'b1);
      end
    end
    exp_ready = 1'b1;
  endtask

  task automatic model_reset();
    pending     = 1'b0;
    exp_ready   = 1'b0;
    held_tone   = '0;
    held_status = '0;
  endtask

  task automatic drive(input bit v, input logic [7:0] b);
    ByteValid = v;
    ByteIn    = b;
    @(posedge CLK);
    #1;
    model_step(v, b);
    ByteValid = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      chk("byte_ready", 32'(ByteReady), 32'(exp_ready));
      chk("tone_value", 32'(ToneValue), 32'(held_tone));
      chk("status_value", 32'(Status), 32'(held_status));
      if (ToneWE != 0 || StatusWE != 0 || CmdError) begin
        if (q.size() == 0) begin
          chk("spurious_strobe", {ToneWE, StatusWE, CmdError}, 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          chk("tone_we", 32'(ToneWE), 32'(e.tone_we));
          chk("status_we", 32'(StatusWE), 32'(e.status_we));
          chk("cmd_error", 32'(CmdError), 32'(e.err));
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("missing_strobe", {ToneWE, StatusWE, CmdError},
            {e.tone_we, e.status_we, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(ByteReady), 32'h0);
    chk("rst_tone_value", 32'(ToneValue), 32'h0);
    chk("rst_tone_we", 32'(ToneWE), 32'h0);
    chk("rst_status", 32'(Status), 32'h0);
    chk("rst_status_we", 32'(StatusWE), 32'h0);
    chk("rst_cmd_error", 32'(CmdError), 32'h0);
    RST = 1'b1;
    repeat (3) drive(1'b0, 8'h00);

    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h3C);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'hFE);
    drive(1'b1, 8'hC4);
    drive(1'b1, 8'h42);
    drive(1'b1, 8'h8F);
    drive(1'b1, 8'hFF);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h91);
    repeat (TIMEOUT) drive(1'b0, 8'h00);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hA7);
    repeat (TIMEOUT - 1) drive(1'b0, 8'h00);
    drive(1'b1, 8'h5A);
    drive(1'b1, 8'hC0);
    drive(1'b0, 8'h00);

    drive(1'b1, 8'hB2);
    RST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h11);

    for (int i = 0; i < 400; i++) begin
      bit v;
      v = ($urandom_range(0, 9) < 6);
      drive(v, 8'($urandom));
    end

    repeat (TIMEOUT + 2) drive(1'b0, 8'h00);
    @(negedge CLK);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/command_decoder.md
Name: command_decoder

Overview:
Host-side writer for the tone/status register bank. It accepts a byte stream from the host interface over a valid/ready handshake and decodes one- and two-byte commands. From these it generates the ToneValue/ToneWE and Status/StatusWE write strobes that load the per-channel tone and status registers. It sits between the host byte interface and the register unit.

Parameters:
TIMEOUT, 1023, maximum idle cycles allowed in WAIT_LO before a pending tone command is aborted (must be >= 1).
TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-low reset
ByteIn  input  8  command/data byte from host
ByteValid  input  1  ByteIn is valid this cycle
ByteReady  output  1  decoder can accept a byte; byte transferred when ByteValid & ByteReady at rising edge
ToneValue  output  12  tone word to write
ToneWE  output  4  one-hot tone write enable, bit n = channel n, single-cycle pulse
Status  output  8  status data, 2 bits per channel at [2n+1:2n]
StatusWE  output  8  per-bit status write enables, single-cycle pulse
CmdError  output  1  single-cycle pulse on protocol error or timeout

Behaviour:
- Reset (async, RST=0):
  - ToneValue=0, ToneWE=0, Status=0, StatusWE=0, CmdError=0, ByteReady=0.
  - FSM=IDLE; latched channel, high nibble and timeout counter cleared.
- ByteReady: registered; goes to 1 on the first clock after RST deasserts, then stays 1. The decoder never back-pressures after reset.
- Command formats:
  - Tone header: ByteIn[7:6]=2'b10, ch=ByteIn[5:4], hi=ByteIn[3:0] (tone[11:8]). The next accepted byte is tone[7:0], with any value.
  - Status command: ByteIn[7:6]=2'b11, ch=ByteIn[5:4], mask=ByteIn[3:2], val=ByteIn[1:0].
  - ByteIn[7]=0 while in IDLE: stray data byte. It is dropped and CmdError pulses.
- FSM states IDLE, WAIT_LO:
  - IDLE + accepted tone header: latch ch and hi, clear the timeout counter, go to WAIT_LO.
  - IDLE + accepted status command: stay in IDLE. On the next cycle:
    - StatusWE[2ch+1:2ch] = mask and Status[2ch+1:2ch] = val.
    - All other StatusWE bits are 0; all other Status bits are 0.
    - mask=0 is legal and produces no enables and no error.
  - WAIT_LO + accepted byte (any value, including bit7=1): go to IDLE. On the next cycle, ToneValue={hi, ByteIn} and ToneWE = 1<<ch.
  - WAIT_LO with no accepted byte: the counter increments. When the counter == TIMEOUT-1 and no byte is accepted, go to IDLE. CmdError pulses on the next cycle, the header is discarded and no ToneWE is issued.
  - A byte accepted in the same cycle the counter reaches its limit wins: the tone write completes and there is no error.
- Latency: write strobes and CmdError appear exactly 1 cycle after the accepting edge. Each is a single-cycle pulse; back-to-back commands give back-to-back pulses.
- Output values between strobes:
  - ToneValue holds its last written value.
  - Status holds its last driven value.
  - Consumers sample these only with their WE.
- At most one of ToneWE, StatusWE or CmdError is non-zero in any cycle.
- Reset asserted mid-command: the pending header is lost and no strobe is generated after release.

Decomposition:
- Shared package ssg_cmd_pkg holds:
  - opcode constants OP_TONE=2'b10 and OP_STATUS=2'b11;
  - field bit positions;
  - the FSM state encoding;
  - channel count NUM_CH=4.
- One natural sub-module: cmd_timeout_counter, a loadable, clearable counter with a terminal-count flag, parameterised by TIMEOUT/TO_W.

Test Plan:
- Reset then idle 3 cycles -> all outputs 0; ByteReady=1 from the first post-reset cycle.
- Bytes 0xA5, 0x3C on consecutive cycles -> one cycle after 0x3C, ToneWE=4'b0100 and ToneValue=12'h53C for exactly 1 cycle.
- Byte 0xFE (ch3, mask=11, val=10) -> next cycle StatusWE=8'hC0 and Status=8'h80. Byte 0xC4 (ch0, mask=01, val=00) -> StatusWE=8'h01, Status=8'h00.
- Byte 0x42 in IDLE -> CmdError pulse, no WE. Then 0x8F, 0xFF -> ToneWE=4'b0001, ToneValue=12'hFFF, with the data byte not treated as a header.
- TIMEOUT=4: send 0x91, then no byte for 4 cycles -> CmdError pulse, no ToneWE. The following 0x00 is flagged as stray (CmdError).
- Send 0xB2, then assert RST for 1 cycle, then 0x11 -> no ToneWE; CmdError pulses (stray byte).
